mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - Load/store sequencer directly upstream of the 8-bit data memory (ports Rm, Wm, address, RegVal, Data_out).
// - Accepts one load or store from execute via valid/ready and drives the memory strobes, never both at once.
// - Data_out appears one cycle after Rm is sampled; this block times that capture.
// - Returns load data plus destination tag to writeback via valid/ready; pulses st_done on store completion.
// PARAMETERS
// - ADDR_W    8      memory address width
// - DATA_W    8      data width
// - TAG_W     3      destination-register tag width
// - MEM_LIMIT 8'hF0  first reserved address; used only with MEM_ACC_BOUNDS_EN
// PORTS
// - clock      in   1       single clock, all state updates on posedge
// - reset      in   1       synchronous, active-high
// - req_valid  in   1       request present
// - req_ready  out  1       unit can accept; 1 only in IDLE
// - req_we     in   1       1=store, 0=load
// - req_addr   in   ADDR_W  memory address
// - req_wdata  in   DATA_W  store data
// - req_rd     in   TAG_W   load destination tag
// - wb_valid   out  1       load result valid
// - wb_ready   in   1       writeback accepts result
// - wb_data    out  DATA_W  loaded byte
// - wb_rd      out  TAG_W   tag of loaded byte
// - st_done    out  1       one-cycle pulse: store written
// - fault      out  1       one-cycle pulse: request rejected (0 when MEM_ACC_BOUNDS_EN is off)
// - mem_rm     out  1       to memory Rm
// - mem_wm     out  1       to memory Wm
// - mem_addr   out  ADDR_W  to memory address
// - mem_wdata  out  DATA_W  to memory RegVal
// - mem_rdata  in   DATA_W  from memory Data_out
// BEHAVIOUR
// - States: IDLE, WR, RD, CAP, RESP. Accept = req_valid & req_ready at a posedge; addr/wdata/we/rd latched then.
// - IDLE: accept & we -> WR; accept & !we -> RD; otherwise stay.
// - WR: mem_wm=1, mem_addr/mem_wdata from latches; -> IDLE; st_done=1 in the cycle after WR.
// - RD: mem_rm=1, mem_addr from latch; -> CAP. The memory registers Data_out on this edge.
// - CAP: mem_rdata sampled into wb_data register; -> RESP.
// - RESP: wb_valid=1, wb_data/wb_rd stable; wb_ready -> IDLE, else hold.
// - Load latency: accept edge T -> wb_valid high from T+3. Store: mem_wm during T+1, st_done during T+2.
// - Throughput: one request in flight; back-to-back accept when IDLE reached.
// - mem_rm and mem_wm are never both 1; outside RD/WR both are 0. mem_addr/mem_wdata hold last latched values.
// - Reset values: state=IDLE, req_ready=1 (after reset deasserts), wb_valid=0, st_done=0, fault=0, mem_rm=0, mem_wm=0,
//   mem_addr=0, mem_wdata=0, wb_data=0, wb_rd=0.
// - Reset mid-operation: in-flight request dropped, no wb_valid/st_done emitted, memory contents unaffected beyond writes already strobed.
// - req_valid in non-IDLE: ignored (req_ready=0); requester must hold.
// - Address wrap: none; addresses used verbatim, 8'hFF is valid.
// CONFIGURATION
// - MEM_ACC_BOUNDS_EN defined: at accept, req_addr >= MEM_LIMIT is rejected: no mem strobe, no wb_valid/st_done,
//   fault=1 for the single cycle after accept, then IDLE.
// - MEM_ACC_BOUNDS_EN undefined: no check, fault tied 0, MEM_LIMIT unused.
// STRUCTURE
// - Package mem_access_pkg: state enum (IDLE, WR, RD, CAP, RESP), ADDR_W/DATA_W/TAG_W defaults, MEM_LIMIT default.
// - Sub-module mem_resp_slot: one-entry valid/ready holding register for wb_data/wb_rd;
//   loaded from CAP, cleared on wb_ready.
// - FSM and request latches in the top module.
// TESTING
// - Bench instantiates this block with the real data memory.
// - Store 8'h5A @8'h10, then load 8'h10 tag 3 -> mem_wm one cycle; load: wb_valid at T+3, wb_data=8'h5A, wb_rd=3.
// - Load with wb_ready=0 for 4 cycles -> wb_valid/wb_data/wb_rd held stable; req_ready=0 throughout; IDLE after wb_ready.
// - Back-to-back stores @8'h00..8'h03 with req_valid constant -> one accept per 2 cycles; st_done 4 times; never mem_rm&mem_wm.
// - Reset in RD of a load -> no wb_valid ever; all outputs at reset values the next cycle; following load @8'hFF works.
// - MEM_ACC_BOUNDS_EN on: store @8'hF0 -> fault one cycle, mem_wm stays 0; load @8'hEF -> normal. Off: @8'hF0 works normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the load/store sequencer in front of the data memory.
package mem_access_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned TAG_W_DEF  = 3;
  localparam logic [7:0]  MEM_LIMIT_DEF = 8'hF0;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWr   = 3'd1,
    StRd   = 3'd2,
    StCap  = 3'd3,
    StResp = 3'd4
  } state_e;

endpackage

// File: rtl/mem_resp_slot.sv
// One-entry valid/ready holding register for a load result (data plus destination tag).
module mem_resp_slot #(
  parameter int unsigned DataW = 8,
  parameter int unsigned TagW  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  input  logic [TagW-1:0]  tag_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic [TagW-1:0]  tag_o
);

  logic             valid_q, valid_d;
  logic [DataW-1:0] data_q, data_d;
  logic [TagW-1:0]  tag_q, tag_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      tag_d   = tag_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer driving the byte-wide data memory's Rm/Wm strobes, one request in flight.
// Optional MEM_ACC_BOUNDS_EN: requests at or above MEM_LIMIT are rejected with a one-cycle fault.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_access_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = mem_access_pkg::DATA_W_DEF,
  parameter int unsigned TAG_W  = mem_access_pkg::TAG_W_DEF
`ifdef MEM_ACC_BOUNDS_EN
  ,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(mem_access_pkg::MEM_LIMIT_DEF)
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_rd,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]  wb_rd,
  output logic              st_done,
  output logic              fault,
  output logic              mem_rm,
  output logic              mem_wm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TAG_W-1:0]  rd_q, rd_d;
  logic              st_done_q, st_done_d;
  logic              fault_q, fault_d;
  logic              accept, reject, cap_load;

`ifdef MEM_ACC_BOUNDS_EN
  assign reject = (req_addr >= MEM_LIMIT);
`else
  assign reject = 1'b0;
`endif

  assign accept = req_valid && req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      st_done_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      st_done_q <= st_done_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !reject) state_d = req_we ? StWr : StRd;
      end
      StWr:    state_d = StIdle;
      StRd:    state_d = StCap;
      StCap:   state_d = StResp;
      StResp: begin
        if (wb_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A rejected request leaves the latches (and thus the memory bus) untouched.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    if (accept && !reject) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      rd_d    = req_rd;
    end
    st_done_d = (state_q == StWr);
    fault_d   = accept && reject;
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    mem_wm    = (state_q == StWr);
    mem_rm    = (state_q == StRd);
    cap_load  = (state_q == StCap);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign st_done   = st_done_q;
  assign fault     = fault_q;

  // Memory output registered on the RD edge is stable during CAP.
  mem_resp_slot #(
    .DataW (DATA_W),
    .TagW  (TAG_W)
  ) u_resp_slot (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (cap_load),
    .data_i  (mem_rdata),
    .tag_i   (rd_q),
    .ready_i (wb_ready),
    .valid_o (wb_valid),
    .data_o  (wb_data),
    .tag_o   (wb_rd)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural byte memory and a high-level memory-content model.
module tb_mem_access_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [2:0] req_rd = '0;
  logic       wb_valid;
  logic       wb_ready = 1'b0;
  logic [7:0] wb_data;
  logic [2:0] wb_rd;
  logic       st_done;
  logic       fault;
  logic       mem_rm;
  logic       mem_wm;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int errs = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic       mem_clr = 1'b1;
  logic [7:0] model_mem [256];

  int st_done_cnt = 0;
  int wm_cnt = 0;
  int both_cnt = 0;
  int wbv_cnt = 0;

  mem_access_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .st_done   (st_done),
    .fault     (fault),
    .mem_rm    (mem_rm),
    .mem_wm    (mem_wm),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous data memory: Data_out registered one cycle after Rm.
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_wm) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rm) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (st_done) st_done_cnt++;
      if (mem_wm) wm_cnt++;
      if (mem_rm && mem_wm) both_cnt++;
      if (wb_valid) wbv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_store(input logic [7:0] addr, input logic [7:0] data);
    checks++;
    if (req_ready !== 1'b1) begin
      errs++;
      $display("FAIL store_ready got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    req_rd = 3'($urandom);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({mem_wm, mem_rm, req_ready, st_done, mem_addr, mem_wdata} !== {4'b1000, addr, data}) begin
      errs++;
      $display("FAIL store_wr wm/rm/rdy/sd/addr/wdata got=%b%b%b%b %h %h want=1000 %h %h",
               mem_wm, mem_rm, req_ready, st_done, mem_addr, mem_wdata, addr, data);
    end
    tick();
    checks++;
    if ({mem_wm, mem_rm, st_done, req_ready} !== 4'b0011) begin
      errs++;
      $display("FAIL store_done wm/rm/sd/rdy got=%b%b%b%b want=0011",
               mem_wm, mem_rm, st_done, req_ready);
    end
    model_mem[addr] = data;
    tick();
    checks++;
    if (st_done !== 1'b0) begin
      errs++;
      $display("FAIL store_pulse st_done got=%b want=0", st_done);
    end
  endtask

  task automatic do_load(input logic [7:0] addr, input logic [2:0] tag, input int hold);
    logic [7:0] exp_d;
    exp_d = model_mem[addr];
    checks++;
    if (req_ready !== 1'b1) begin
      errs++;
      $display("FAIL load_ready got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_rd = tag;
    req_wdata = 8'($urandom);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({mem_rm, mem_wm, wb_valid, req_ready, mem_addr} !== {4'b1000, addr}) begin
      errs++;
      $display("FAIL load_rd rm/wm/wbv/rdy/addr got=%b%b%b%b %h want=1000 %h",
               mem_rm, mem_wm, wb_valid, req_ready, mem_addr, addr);
    end
    tick();
    checks++;
    if ({mem_rm, wb_valid, req_ready} !== 3'b000) begin
      errs++;
      $display("FAIL load_cap rm/wbv/rdy got=%b%b%b want=000", mem_rm, wb_valid, req_ready);
    end
    tick();
    checks++;
    if ({wb_valid, wb_data, wb_rd} !== {1'b1, exp_d, tag}) begin
      errs++;
      $display("FAIL load_resp v/data/rd got=%b %h %0d want=1 %h %0d",
               wb_valid, wb_data, wb_rd, exp_d, tag);
    end
    for (int k = 0; k < hold; k++) begin
      tick();
      checks++;
      if ({wb_valid, req_ready, wb_data, wb_rd} !== {2'b10, exp_d, tag}) begin
        errs++;
        $display("FAIL load_hold%0d v/rdy/data/rd got=%b%b %h %0d want=10 %h %0d",
                 k, wb_valid, req_ready, wb_data, wb_rd, exp_d, tag);
      end
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++;
    if ({wb_valid, req_ready} !== 2'b01) begin
      errs++;
      $display("FAIL load_release v/rdy got=%b%b want=01", wb_valid, req_ready);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if ({req_ready, wb_valid, st_done, fault, mem_rm, mem_wm} !== 6'b100000) begin
      errs++;
      $display("FAIL %s_ctl rdy/wbv/sd/flt/rm/wm got=%b%b%b%b%b%b want=100000", nm,
               req_ready, wb_valid, st_done, fault, mem_rm, mem_wm);
    end
    checks++;
    if ({mem_addr, mem_wdata, wb_data, wb_rd} !== 27'd0) begin
      errs++;
      $display("FAIL %s_data addr/wdata/wbdata/wbrd got=%h %h %h %0d want=0 0 0 0", nm,
               mem_addr, mem_wdata, wb_data, wb_rd);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    reset = 1'b1; mem_clr = 1'b1;
    repeat (3) tick();
    reset = 1'b0; mem_clr = 1'b0;
    check_reset_vals("reset");
    tick();
    check_reset_vals("idle");
  endtask

  task automatic test_store_load();
    int wm0;
    wm0 = wm_cnt;
    do_store(8'h10, 8'h5A);
    checks++;
    if (wm_cnt - wm0 !== 1) begin
      errs++;
      $display("FAIL store_wm_cycles got=%0d want=1", wm_cnt - wm0);
    end
    do_load(8'h10, 3'd3, 0);
  endtask

  task automatic test_load_stall();
    do_load(8'h10, 3'd5, 4);
  endtask

  task automatic test_back_to_back();
    int acc_cyc [4];
    int idx, sd0, wm0;
    logic taken;
    sd0 = st_done_cnt; wm0 = wm_cnt; both_cnt = 0; idx = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h00; req_wdata = 8'hA0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      taken = (idx < 4) && req_ready;
      if (taken) acc_cyc[idx] = cyc;
      tick();
      if (taken) begin
        model_mem[req_addr] = req_wdata;
        idx++;
        if (idx < 4) begin
          req_addr = 8'(idx); req_wdata = 8'(8'hA0 + idx);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (idx !== 4) begin
      errs++;
      $display("FAIL b2b_accepts got=%0d want=4", idx);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== 2) begin
          errs++;
          $display("FAIL b2b_spacing%0d got=%0d want=2", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    checks++;
    if ({st_done_cnt - sd0, wm_cnt - wm0} !== {32'd4, 32'd4}) begin
      errs++;
      $display("FAIL b2b_counts st_done/wm got=%0d %0d want=4 4", st_done_cnt - sd0, wm_cnt - wm0);
    end
    checks++;
    if (both_cnt !== 0) begin
      errs++;
      $display("FAIL b2b_rm_and_wm got=%0d want=0", both_cnt);
    end
    do_load(8'h02, 3'd1, 1);
  endtask

  task automatic test_reset_mid();
    int v0, s0;
    logic [7:0] a;
`ifdef MEM_ACC_BOUNDS_EN
    a = 8'hEF;
`else
    a = 8'hFF;
`endif
    do_store(a, 8'hC3);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_rd = 3'd6;
    tick();
    req_valid = 1'b0;
    checks++;
    if (mem_rm !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_in_rd mem_rm got=%b want=1", mem_rm);
    end
    v0 = wbv_cnt; s0 = st_done_cnt;
    reset = 1'b1;
    tick();
    check_reset_vals("rstmid");
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if ({wbv_cnt - v0, st_done_cnt - s0} !== 64'd0) begin
      errs++;
      $display("FAIL rstmid_dropped wbv/sd cycles got=%0d %0d want=0 0",
               wbv_cnt - v0, st_done_cnt - s0);
    end
    do_load(a, 3'd7, 1);
  endtask

  task automatic test_bounds();
`ifdef MEM_ACC_BOUNDS_EN
    int wm0, s0;
    wm0 = wm_cnt; s0 = st_done_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hF0; req_wdata = 8'h3C;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({fault, mem_wm, st_done} !== 3'b100) begin
      errs++;
      $display("FAIL bounds_fault flt/wm/sd got=%b%b%b want=100", fault, mem_wm, st_done);
    end
    tick();
    checks++;
    if ({fault, mem_wm, st_done, req_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL bounds_after flt/wm/sd/rdy got=%b%b%b%b want=0001",
               fault, mem_wm, st_done, req_ready);
    end
    tick();
    checks++;
    if ({wm_cnt - wm0, st_done_cnt - s0} !== 64'd0) begin
      errs++;
      $display("FAIL bounds_no_write wm/sd got=%0d %0d want=0 0", wm_cnt - wm0, st_done_cnt - s0);
    end
    do_load(8'hEF, 3'd2, 0);
`else
    do_store(8'hF0, 8'h3C);
    checks++;
    if (fault !== 1'b0) begin
      errs++;
      $display("FAIL nobounds_fault got=%b want=0", fault);
    end
    do_load(8'hF0, 3'd2, 0);
`endif
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 40; n++) begin
`ifdef MEM_ACC_BOUNDS_EN
      a = 8'($urandom_range(239, 0));
`else
      a = ($urandom % 2 == 0) ? 8'($urandom_range(15, 0)) : 8'($urandom);
`endif
      if ($urandom % 2 == 0) do_store(a, 8'($urandom));
      else do_load(a, 3'($urandom), int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_load_stall();
    test_back_to_back();
    test_reset_mid();
    test_bounds();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
